// File: rtl/mqnic_tx_req_limiter.sv
// TX request limiter: gates scheduler requests on outstanding count
// and byte budget, tracking completions by snooping status streams.
module mqnic_tx_req_limiter #(
  parameter int QUEUE_INDEX_WIDTH = 13,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int REQ_DEST_WIDTH    = 5,
  parameter int DMA_LEN_WIDTH     = 16,
  parameter int CNT_WIDTH         = 8,
  parameter int BYTE_WIDTH        = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_tx_req_queue,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_tx_req_tag,
  input  logic [REQ_DEST_WIDTH-1:0]    s_axis_tx_req_dest,
  input  logic                         s_axis_tx_req_valid,
  output logic                         s_axis_tx_req_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_tx_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_tx_req_tag,
  output logic [REQ_DEST_WIDTH-1:0]    m_axis_tx_req_dest,
  output logic                         m_axis_tx_req_valid,
  input  logic                         m_axis_tx_req_ready,
  input  logic                         s_axis_tx_status_dequeue_empty,
  input  logic                         s_axis_tx_status_dequeue_error,
  input  logic                         s_axis_tx_status_dequeue_valid,
  input  logic                         s_axis_tx_status_start_error,
  input  logic                         s_axis_tx_status_start_valid,
  input  logic [DMA_LEN_WIDTH-1:0]     s_axis_tx_status_start_len,
  input  logic [DMA_LEN_WIDTH-1:0]     s_axis_tx_status_finish_len,
  input  logic                         s_axis_tx_status_finish_valid,
  input  logic [DMA_LEN_WIDTH-1:0]     mtu,
  input  logic                         cfg_enable,
  input  logic [CNT_WIDTH-1:0]         cfg_max_outstanding,
  input  logic [BYTE_WIDTH-1:0]        cfg_max_bytes,
  output logic [CNT_WIDTH-1:0]         stat_outstanding,
  output logic [BYTE_WIDTH-1:0]        stat_bytes,
  output logic                         stat_underflow,
  output logic                         active
);

  localparam int W  = BYTE_WIDTH + 2;
  localparam int CW = CNT_WIDTH + 1;
  localparam int AW = BYTE_WIDTH + 1;

  logic                         m_valid_q, m_valid_d;
  logic [QUEUE_INDEX_WIDTH-1:0] queue_q;
  logic [REQ_TAG_WIDTH-1:0]     tag_q;
  logic [REQ_DEST_WIDTH-1:0]    dest_q;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [BYTE_WIDTH-1:0]        bytes_q, bytes_d;
  logic [DMA_LEN_WIDTH-1:0]     mtu_q, mtu_d;
  logic                         uf_q, uf_d;

  logic          allow, admit;
  logic          ev_deq, ev_serr, ev_sok, ev_fin;
  logic [AW-1:0] need;
  logic [CW-1:0] c_n;
  logic [W-1:0]  b_n, mtu_x, sl_x, fl_x;

  assign need = {1'b0, bytes_q}
              + {{(AW-DMA_LEN_WIDTH){1'b0}}, mtu_q};

  assign allow = cfg_enable
              && (cnt_q < cfg_max_outstanding)
              && (need <= {1'b0, cfg_max_bytes});

  assign s_axis_tx_req_ready = !rst && allow
    && (!m_valid_q || m_axis_tx_req_ready);

  assign admit = s_axis_tx_req_valid && s_axis_tx_req_ready;

  assign ev_deq  = s_axis_tx_status_dequeue_valid
    && (s_axis_tx_status_dequeue_empty
        || s_axis_tx_status_dequeue_error);
  assign ev_serr = s_axis_tx_status_start_valid
    && s_axis_tx_status_start_error;
  assign ev_sok  = s_axis_tx_status_start_valid
    && !s_axis_tx_status_start_error;
  assign ev_fin  = s_axis_tx_status_finish_valid;

  assign mtu_x = {{(W-DMA_LEN_WIDTH){1'b0}}, mtu_q};
  assign sl_x  = {{(W-DMA_LEN_WIDTH){1'b0}},
                  s_axis_tx_status_start_len};
  assign fl_x  = {{(W-DMA_LEN_WIDTH){1'b0}},
                  s_axis_tx_status_finish_len};

  // Sum all same-cycle deltas, then saturate at zero on underflow
  always_comb begin
    c_n = {1'b0, cnt_q};
    b_n = {2'b00, bytes_q};
    if (admit) begin
      c_n = c_n + CW'(1);
      b_n = b_n + mtu_x;
    end
    if (ev_deq) begin
      c_n = c_n - CW'(1);
      b_n = b_n - mtu_x;
    end
    if (ev_serr) begin
      c_n = c_n - CW'(1);
      b_n = b_n - mtu_x;
    end
    if (ev_sok) begin
      b_n = b_n - mtu_x + sl_x;
    end
    if (ev_fin) begin
      c_n = c_n - CW'(1);
      b_n = b_n - fl_x;
    end
    uf_d = uf_q;
    if (c_n[CW-1]) begin
      cnt_d = '0;
      uf_d  = 1'b1;
    end else begin
      cnt_d = c_n[CNT_WIDTH-1:0];
    end
    if (b_n[W-1]) begin
      bytes_d = '0;
      uf_d    = 1'b1;
    end else if (b_n[W-2]) begin
      bytes_d = '1;
    end else begin
      bytes_d = b_n[BYTE_WIDTH-1:0];
    end
    mtu_d = mtu_q;
    if (cnt_q == '0 && !admit) begin
      mtu_d = mtu;
    end
    m_valid_d = m_valid_q;
    if (admit) begin
      m_valid_d = 1'b1;
    end else if (m_axis_tx_req_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Control and accounting state
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
      bytes_q   <= '0;
      mtu_q     <= '0;
      uf_q      <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      cnt_q     <= cnt_d;
      bytes_q   <= bytes_d;
      mtu_q     <= mtu_d;
      uf_q      <= uf_d;
    end
  end

  // Output payload register, loaded only on admit
  always_ff @(posedge clk) begin
    if (admit) begin
      queue_q <= s_axis_tx_req_queue;
      tag_q   <= s_axis_tx_req_tag;
      dest_q  <= s_axis_tx_req_dest;
    end
  end

  assign m_axis_tx_req_valid = m_valid_q;
  assign m_axis_tx_req_queue = queue_q;
  assign m_axis_tx_req_tag   = tag_q;
  assign m_axis_tx_req_dest  = dest_q;
  assign stat_outstanding    = cnt_q;
  assign stat_bytes          = bytes_q;
  assign stat_underflow      = uf_q;
  assign active              = cnt_q != '0;

endmodule
